regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) between two requesters: A = pipeline writeback, B = Morse I/O decode unit.
- Each requester gets a one-entry holding buffer.
- Arbitration is round-robin, with age ordering for same-register collisions.
- Flags decode-stage read addresses that hit a pending write, using 5-bit address equality, so the pipeline can stall.

---
 rtl/regfile_wr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the register-file write port: one-entry buffers, round-robin
// with age ordering on same-register collisions, read-hazard flags. Optional forwarding: REGARB_FWD_EN.
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_hit1,
  output logic              rd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  logic              r_a_vld;
  logic              r_b_vld;
  logic [ADDR_W-1:0] r_a_addr;
  logic [ADDR_W-1:0] r_b_addr;
  logic [DATA_W-1:0] r_a_data;
  logic [DATA_W-1:0] r_b_data;
  logic              r_a_older;
  logic              r_last_b;

  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_load_a;
  logic              w_load_b;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  // Grant looks at buffered entries only, so a request is never granted on arrival.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (r_a_vld && r_b_vld) begin
      if (r_a_addr == r_b_addr) begin
        w_gnt_a = r_a_older;
        w_gnt_b = !r_a_older;
      end else begin
        w_gnt_a = r_last_b;
        w_gnt_b = !r_last_b;
      end
    end else begin
      w_gnt_a = r_a_vld;
      w_gnt_b = r_b_vld;
    end
  end

  assign a_ready    = !r_a_vld | w_gnt_a;
  assign b_ready    = !r_b_vld | w_gnt_b;
  assign w_load_a   = a_req & a_ready & (a_addr != '0);
  assign w_load_b   = b_req & b_ready & (b_addr != '0);
  assign w_sel_addr = w_gnt_a ? r_a_addr : r_b_addr;
  assign w_sel_data = w_gnt_a ? r_a_data : r_b_data;

  // Buffer control: a refill wins over the clear of a granted entry.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      r_a_vld   <= 1'b0;
      r_b_vld   <= 1'b0;
      r_a_older <= 1'b1;
      r_last_b  <= 1'b1;
    end else begin
      if (w_load_a)     r_a_vld <= 1'b1;
      else if (w_gnt_a) r_a_vld <= 1'b0;
      if (w_load_b)     r_b_vld <= 1'b1;
      else if (w_gnt_b) r_b_vld <= 1'b0;
      if (w_load_a && w_load_b) r_a_older <= 1'b1;
      else if (w_load_a)        r_a_older <= 1'b0;
      else if (w_load_b)        r_a_older <= 1'b1;
      if (w_gnt_a)      r_last_b <= 1'b0;
      else if (w_gnt_b) r_last_b <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_load_a) begin
      r_a_addr <= a_addr;
      r_a_data <= a_data;
    end
    if (w_load_b) begin
      r_b_addr <= b_addr;
      r_b_data <= b_data;
    end
  end

  // Write-port output stage
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (w_gnt_a || w_gnt_b) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= w_sel_addr;
      data_writeReg    <= w_sel_data;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

  logic w_m1_a, w_m1_b, w_m1_w, w_nz1;
  logic w_m2_a, w_m2_b, w_m2_w, w_nz2;

  assign w_nz1  = (rd_addr1 != '0);
  assign w_m1_a = r_a_vld && (r_a_addr == rd_addr1);
  assign w_m1_b = r_b_vld && (r_b_addr == rd_addr1);
  assign w_m1_w = ctrl_writeEnable && (ctrl_writeReg == rd_addr1);
  assign w_nz2  = (rd_addr2 != '0);
  assign w_m2_a = r_a_vld && (r_a_addr == rd_addr2);
  assign w_m2_b = r_b_vld && (r_b_addr == rd_addr2);
  assign w_m2_w = ctrl_writeEnable && (ctrl_writeReg == rd_addr2);

  assign rd_hit1 = w_nz1 && (w_m1_a || w_m1_b || w_m1_w);
  assign rd_hit2 = w_nz2 && (w_m2_a || w_m2_b || w_m2_w);

`ifdef REGARB_FWD_EN
  // Youngest matching source wins: younger buffer, then older buffer, then output stage.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic              nz,
    input logic              ma,
    input logic              mb,
    input logic              mw,
    input logic              a_older,
    input logic [DATA_W-1:0] da,
    input logic [DATA_W-1:0] db,
    input logic [DATA_W-1:0] dw
  );
    logic [DATA_W-1:0] res;
    res = '0;
    if (!nz)           res = '0;
    else if (ma && mb) res = a_older ? db : da;
    else if (ma)       res = da;
    else if (mb)       res = db;
    else if (mw)       res = dw;
    return res;
  endfunction

  assign fwd_data1 = fwd_sel(w_nz1, w_m1_a, w_m1_b, w_m1_w, r_a_older,
                             r_a_data, r_b_data, data_writeReg);
  assign fwd_data2 = fwd_sel(w_nz2, w_m2_a, w_m2_b, w_m2_w, r_a_older,
                             r_a_data, r_b_data, data_writeReg);
`else
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic against a
// timestamp-ordered reference model of the pending writes.
module tb_regfile_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          ctrl_reset_n;
  logic          a_req, b_req;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic          rd_hit1, rd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic          ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg;
  logic [DW-1:0] data_writeReg;

  always #5 clock = ~clock;

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_hit1(rd_hit1), .rd_hit2(rd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending writes tagged with load timestamps (smaller = older).
  logic          m_v[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data[2];
  int            m_seq[2];
  int            m_ctr;
  int            m_last;
  logic          m_we;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;

  logic          p_ar, p_br, p_h1, p_h2;
  logic [DW-1:0] p_f2;
  logic          o_we;
  logic [AW-1:0] o_wreg;
  logic [DW-1:0] o_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_v[0] = 1'b0; m_v[1] = 1'b0;
    m_seq[0] = 0; m_seq[1] = 0;
    m_ctr = 2; m_last = 1;
    m_we = 1'b0; m_wreg = '0; m_wdata = '0;
  endtask

  function automatic int m_grant();
    if (m_v[0] && m_v[1]) begin
      if (m_addr[0] == m_addr[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
      return (m_last == 1) ? 0 : 1;
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  function automatic logic m_hit(input logic [AW-1:0] rd);
    if (rd == '0) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (m_v[i] && m_addr[i] == rd) return 1'b1;
    return m_we && (m_wreg == rd);
  endfunction

  function automatic logic [DW-1:0] m_fwd(input logic [AW-1:0] rd);
    int best;
    best = -1;
    if (rd == '0) return '0;
    for (int i = 0; i < 2; i++) begin
      if (m_v[i] && m_addr[i] == rd) begin
        if (best < 0) best = i;
        else if (m_seq[i] > m_seq[best]) best = i;
      end
    end
    if (best >= 0) return m_data[best];
    if (m_we && m_wreg == rd) return m_wdata;
    return '0;
  endfunction

  task automatic drive(input logic ar, input int aa, input logic [DW-1:0] ad,
                       input logic br, input int ba, input logic [DW-1:0] bd);
    a_req = ar; a_addr = aa[AW-1:0]; a_data = ad;
    b_req = br; b_addr = ba[AW-1:0]; b_data = bd;
  endtask

  // One clock: inputs already applied just after the falling edge.
  task automatic cycle();
    int            g;
    logic          rdy[2];
    logic          rq[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] dt[2];
    #1;
    g = m_grant();
    rdy[0] = !m_v[0] || (g == 0);
    rdy[1] = !m_v[1] || (g == 1);
    p_ar = a_ready; p_br = b_ready; p_h1 = rd_hit1; p_h2 = rd_hit2; p_f2 = fwd_data2;
    chk("a_ready", a_ready, rdy[0]);
    chk("b_ready", b_ready, rdy[1]);
    chk("rd_hit1", rd_hit1, m_hit(rd_addr1));
    chk("rd_hit2", rd_hit2, m_hit(rd_addr2));
`ifdef REGARB_FWD_EN
    chk("fwd_data1", fwd_data1, m_fwd(rd_addr1));
    chk("fwd_data2", fwd_data2, m_fwd(rd_addr2));
`else
    chk("fwd_data1", fwd_data1, 0);
    chk("fwd_data2", fwd_data2, 0);
`endif
    rq[0] = a_req; ad[0] = a_addr; dt[0] = a_data;
    rq[1] = b_req; ad[1] = b_addr; dt[1] = b_data;
    if (!ctrl_reset_n) begin
      m_reset();
    end else begin
      if (g >= 0) begin
        m_we = 1'b1; m_wreg = m_addr[g]; m_wdata = m_data[g]; m_last = g; m_v[g] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (rq[i] && rdy[i] && ad[i] != '0) begin
          m_v[i] = 1'b1; m_addr[i] = ad[i]; m_data[i] = dt[i]; m_seq[i] = m_ctr + i;
        end
      end
      m_ctr += 2;
    end
    @(posedge clock);
    #1;
    o_we = ctrl_writeEnable; o_wreg = ctrl_writeReg; o_wdata = data_writeReg;
    chk("writeEnable", ctrl_writeEnable, m_we);
    chk("writeReg", ctrl_writeReg, m_wreg);
    chk("writeData", data_writeReg, m_wdata);
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] wq[$];
    logic [DW-1:0] dq[$];
    int            exp_alt[8];
    int            ai, bi, nc;
    exp_alt = '{1, 10, 2, 11, 3, 12, 4, 13};

    // Reset held with both requesters asserting
    ctrl_reset_n = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;
    drive(1, 3, 32'h1, 1, 4, 32'h2);
    m_reset();
    @(posedge clock);
    @(negedge clock);
    cycle();
    cycle();
    chk("rst_a_ready", p_ar, 1);
    chk("rst_b_ready", p_br, 1);
    chk("rst_we", o_we, 0);
    chk("rst_wreg", o_wreg, 0);
    chk("rst_wdata", o_wdata, 0);

    // First contest goes to A
    ctrl_reset_n = 1'b1;
    drive(1, 3, 32'h33, 1, 20, 32'h44);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("first_we", o_we, 1);
    chk("first_grant_A", o_wreg, 3);
    chk("first_data", o_wdata, 32'h33);
    cycle();
    chk("second_grant_B", o_wreg, 20);
    cycle();
    chk("idle_we", o_we, 0);

    // Alternation: A streams r1..r4, B streams r10..r13
    ai = 0; bi = 0; nc = 0;
    while (wq.size() < 8 && nc < 40) begin
      drive(ai < 4, 1 + ai, 32'hA00 + ai, bi < 4, 10 + bi, 32'hB00 + bi);
      cycle();
      nc++;
      if (a_req && p_ar) ai++;
      if (b_req && p_br) bi++;
      if (o_we) wq.push_back(o_wreg);
    end
    chk("alt_count", wq.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < wq.size()) chk("alt_order", wq[i], exp_alt[i]);
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    // Single write r7 and its hazard window
    rd_addr1 = 5'd7;
    drive(1, 7, 32'hAA, 0, 0, 0);
    cycle();
    chk("sw_hit_pre", p_h1, 0);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("sw_hit_k", p_h1, 1);
    chk("sw_we", o_we, 1);
    chk("sw_wreg", o_wreg, 7);
    chk("sw_wdata", o_wdata, 32'hAA);
    cycle();
    chk("sw_hit_k1", p_h1, 1);
    chk("sw_we_off", o_we, 0);
    cycle();
    chk("sw_hit_k2", p_h1, 0);
    rd_addr1 = '0;

    // Same-register collision, same edge: A is older
    dq.delete();
    drive(1, 5, 32'h11, 1, 5, 32'h22);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (o_we) dq.push_back(o_wdata);
    end
    chk("col_same_count", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("col_same_first", dq[0], 32'h11);
      chk("col_same_last", dq[1], 32'h22);
    end

    // Collision with B loaded one cycle ahead of A
    dq.delete();
    drive(0, 0, 0, 1, 5, 32'h33);
    cycle();
    drive(1, 5, 32'h44, 0, 0, 0);
    cycle();
    if (o_we) dq.push_back(o_wdata);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (o_we) dq.push_back(o_wdata);
    end
    chk("col_seq_count", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("col_seq_first", dq[0], 32'h33);
      chk("col_seq_last", dq[1], 32'h44);
    end

    // Register 0 writes are swallowed
    rd_addr1 = '0;
    drive(1, 0, 32'hFFFF, 0, 0, 0);
    cycle();
    chk("r0_ready", p_ar, 1);
    chk("r0_hit", p_h1, 0);
    chk("r0_we", o_we, 0);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("r0_ready_after", p_ar, 1);
    chk("r0_we_after", o_we, 0);

    // Reset with both buffers full discards them
    drive(1, 8, 32'h88, 1, 9, 32'h99);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    ctrl_reset_n = 1'b0;
    cycle();
    chk("midrst_we", o_we, 0);
    ctrl_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("midrst_no_write", o_we, 0);
    end

    // Forwarding: B's younger r9 beats A's r9 in the output stage
    rd_addr2 = 5'd9;
    drive(1, 9, 32'h1234, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 1, 9, 32'h5678);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("fwd_hit2", p_h2, 1);
`ifdef REGARB_FWD_EN
    chk("fwd_data2_young", p_f2, 32'h5678);
`else
    chk("fwd_data2_zero", p_f2, 0);
`endif
    cycle();
    cycle();
    rd_addr2 = '0;

    // Random traffic on a small address range to force collisions
    for (int i = 0; i < 400; i++) begin
      ctrl_reset_n = ($urandom_range(0, 39) != 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom);
      rd_addr1 = AW'($urandom_range(0, 7));
      rd_addr2 = AW'($urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
